ibuf_byte_queue: RTL and testbench
==================================

Name: ibuf_byte_queue

Overview:
Instruction byte queue feeding the IFU length/opcode decode stage.
- Accepts fetched bytecode in 1–4 byte groups from the fetch path.
- Presents a 5-byte window (opcode plus up to 4 operand bytes) with a thermometer valid vector that the length decoder consumes directly.
- Retires 1–5 bytes per cycle on the one-hot length returned by the decoder.
- Sits between I-cache fill/align logic and the length decoder.

Parameters:
DEPTH, 16, byte storage entries; power of 2, minimum 8.
PTR_W, 4, log2(DEPTH).

Ports:
clk  input  1  core clock, all state on rising edge.
reset_l  input  1  asynchronous active-low reset.
flush  input  1  discard all queued bytes (branch/trap redirect).
fill_valid  input  1  fill group offered this cycle.
fill_data  input  32  fill bytes; byte k at [8k+7:8k], byte 0 oldest.
fill_cnt  input  3  number of bytes in the group, 1..4; 0 and 5..7 illegal.
fill_ready  output  1  queue can take a full 4-byte group this cycle.
win_data  output  40  bytes rd_ptr..rd_ptr+4; byte 0 (opcode) at [7:0].
win_valid  output  5  thermometer; bit i set when i < occupancy.
cons_len  input  5  one-hot consume length; bit i means retire i+1 bytes; all-zero means no consume.
occ  output  PTR_W+1  current occupancy, 0..DEPTH.
cons_err  output  1  registered one-cycle pulse on an illegal consume.

Behaviour:
Reset (async, reset_l low):
- rd_ptr=0, wr_ptr=0, occ=0, cons_err=0.
- Storage array is not reset.
- Outputs while in reset: win_valid=5'b0, win_data=40'b0, fill_ready=1.

Window:
- Combinational from registered state only; no input-to-window path.
- Byte i is mem[(rd_ptr+i) mod DEPTH] when i < occ, else forced to 8'h00.
- Pointers wrap modulo DEPTH; the window read wraps seamlessly across entry DEPTH-1 to entry 0.

Fill:
- fill_ready = !flush & (DEPTH - occ >= 4).
- Ready is computed from registered occ. A consume in the same cycle does not raise ready.
- Accept = fill_valid & fill_ready.
- On accept, bytes 0..fill_cnt-1 are written at wr_ptr..wr_ptr+fill_cnt-1, and wr_ptr advances by fill_cnt.
- Accepted bytes appear in the window the next cycle.
- fill_valid while fill_ready=0: ignored, no state change; the source holds.
- fill_cnt illegal on accept: treated as 0, nothing written, cons_err pulses.

Consume:
- Legal when cons_len is one-hot and its length L <= registered occ.
- A legal consume advances rd_ptr by L.
- Illegal cases: cons_len not one-hot and non-zero, or L > occ. Then no pointer/occ change, and cons_err=1 the next cycle.

Simultaneous fill and consume:
- occ_next = occ + fill_cnt(accepted) - L(legal).
- Both take effect the same edge. Fill never overwrites unconsumed bytes because ready guarantees 4 free entries.

Flush:
- Synchronous and highest priority.
- Next cycle: rd_ptr=wr_ptr=0, occ=0.
- Any same-cycle fill or consume is discarded; no cons_err from a consume in the flush cycle.
- Window valid returns to 0 one cycle after flush.

Reset mid-operation: all queued bytes are lost; state matches reset above.

Full: occ=DEPTH means fill_ready=0 and win_valid=5'b11111.

Empty: occ=0 means win_valid=0; any non-zero cons_len is illegal and pulses cons_err.

Latency: 1 cycle from fill accept to window visibility; 1 cycle from consume to window advance.

Test Plan:
1. Reset, then fill 4 bytes 0x11223344 (fill_cnt=4) -> next cycle win_data[31:0]=0x11223344, win_valid=5'b01111, occ=4, fill_ready=1.
2. Fill 0xB9,0x00,0x05,0x02 then 0x01,0x60 (cnt 4 then 2); consume cons_len=5'b10000 (len 5) -> occ 6→1, win_data[7:0]=0x60, win_valid=5'b00001.
3. Fill 4 bytes per cycle from occ=0 with no consume -> fill_ready drops when occ=16 after 4 accepts; further fill_valid ignored; win_valid=5'b11111.
4. Wrap: rd_ptr=14, occ=4, mem[14..15]=0xA1,0xA2, mem[0..1]=0xA3,0xA4 -> win_data[31:0]=0xA4A3A2A1; consume len 3 -> rd_ptr=1, win_data[7:0]=0xA4.
5. occ=2, cons_len=5'b00100 (len 3) -> no state change, cons_err=1 for exactly one cycle; cons_len=5'b00011 -> cons_err=1, occ stays 2.
6. occ=10, flush with fill_valid=1 and cons_len=5'b00001 in the same cycle -> next cycle occ=0, win_valid=0, cons_err=0, fill_ready=1; assert reset_l low mid-fill -> occ=0 immediately.

Source files
------------

// File: rtl/ibuf_byte_queue_if.sv
// Fill / window / consume signal bundle between the fetch path, the byte queue
// and the length decoder.
interface ibuf_byte_queue_if #(
    parameter int unsigned PTR_W = 4
);
    logic             flush;
    logic             fill_valid;
    logic [31:0]      fill_data;
    logic [2:0]       fill_cnt;
    logic             fill_ready;
    logic [39:0]      win_data;
    logic [4:0]       win_valid;
    logic [4:0]       cons_len;
    logic [PTR_W:0]   occ;
    logic             cons_err;

    modport master (
        output flush, fill_valid, fill_data, fill_cnt, cons_len,
        input  fill_ready, win_data, win_valid, occ, cons_err
    );

    modport slave (
        input  flush, fill_valid, fill_data, fill_cnt, cons_len,
        output fill_ready, win_data, win_valid, occ, cons_err
    );
endinterface

// File: rtl/ibuf_byte_queue.sv
// Instruction byte queue: 1-4 byte fills in, 5-byte decode window out,
// 1-5 byte retire per cycle on a one-hot length.
module ibuf_byte_queue #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned PTR_W = 4
) (
    input logic               clk,
    input logic               reset_l,
    ibuf_byte_queue_if.slave  ibq
);
    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W:0]   occ_r;
    logic             err_r;

    logic             accept;
    logic             cnt_ok;
    logic [3:0]       byte_we;
    logic [2:0]       fill_amt;
    logic [2:0]       req_len;
    logic             bad_code;
    logic             cons_legal;
    logic             cons_bad;
    logic [2:0]       cons_amt;
    logic [PTR_W-1:0] rd_idx [5];

    // Ready looks only at registered occupancy, so a same-cycle consume never raises it.
    always_comb begin
        ibq.fill_ready = !ibq.flush &&
                         ((PTR_W+1)'(DEPTH) - occ_r >= (PTR_W+1)'(4));
        accept = ibq.fill_valid && ibq.fill_ready;

        byte_we = '0;
        cnt_ok  = 1'b1;
        case (ibq.fill_cnt)
            3'd1:    byte_we = 4'b0001;
            3'd2:    byte_we = 4'b0011;
            3'd3:    byte_we = 4'b0111;
            3'd4:    byte_we = 4'b1111;
            default: cnt_ok  = 1'b0;
        endcase
        fill_amt = (accept && cnt_ok) ? ibq.fill_cnt : 3'd0;

        req_len  = 3'd0;
        bad_code = 1'b0;
        case (ibq.cons_len)
            5'b00000: req_len = 3'd0;
            5'b00001: req_len = 3'd1;
            5'b00010: req_len = 3'd2;
            5'b00100: req_len = 3'd3;
            5'b01000: req_len = 3'd4;
            5'b10000: req_len = 3'd5;
            default:  bad_code = 1'b1;
        endcase
        cons_legal = (req_len != 3'd0) && ((PTR_W+1)'(req_len) <= occ_r);
        cons_bad   = bad_code || ((req_len != 3'd0) && !cons_legal);
        cons_amt   = cons_legal ? req_len : 3'd0;
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            occ_r  <= '0;
            err_r  <= 1'b0;
        end else if (ibq.flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            occ_r  <= '0;
            err_r  <= 1'b0;
        end else begin
            rd_ptr <= rd_ptr + PTR_W'(cons_amt);
            wr_ptr <= wr_ptr + PTR_W'(fill_amt);
            occ_r  <= occ_r + (PTR_W+1)'(fill_amt) - (PTR_W+1)'(cons_amt);
            err_r  <= cons_bad || (accept && !cnt_ok);
        end
    end

    // Storage is deliberately left unreset; the window masks stale entries by occupancy.
    always_ff @(posedge clk) begin
        for (int unsigned k = 0; k < 4; k++) begin
            if (accept && byte_we[k])
                mem[wr_ptr + PTR_W'(k)] <= ibq.fill_data[8*k +: 8];
        end
    end

    always_comb begin
        ibq.win_data  = '0;
        ibq.win_valid = '0;
        for (int unsigned i = 0; i < 5; i++) begin
            rd_idx[i] = rd_ptr + PTR_W'(i);
            if (occ_r > (PTR_W+1)'(i)) begin
                ibq.win_valid[i]       = 1'b1;
                ibq.win_data[8*i +: 8] = mem[rd_idx[i]];
            end
        end
        ibq.occ      = occ_r;
        ibq.cons_err = err_r;
    end
endmodule

// File: tb/tb_ibuf_byte_queue.sv
// Randomized bench for ibuf_byte_queue against a byte-queue reference model,
// plus directed scenarios pinned with hand-computed values.
module tb_ibuf_byte_queue;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic reset_l = 1'b0;
    always #5 clk = ~clk;

    ibuf_byte_queue_if #(.PTR_W(4)) bus ();

    ibuf_byte_queue #(.DEPTH(DEPTH), .PTR_W(4)) dut (
        .clk     (clk),
        .reset_l (reset_l),
        .ibq     (bus)
    );

    logic [7:0] mq [$];
    bit         merr;
    int         checks = 0;
    int         errors = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic compare_model();
        logic [39:0] ewin;
        logic [4:0]  evld;
        logic        erdy;
        ewin = '0;
        evld = '0;
        for (int i = 0; i < 5; i++) begin
            if (i < mq.size()) begin
                evld[i] = 1'b1;
                ewin[8*i +: 8] = mq[i];
            end
        end
        erdy = !bus.flush && ((DEPTH - mq.size()) >= 4);
        chk("fill_ready", 64'(bus.fill_ready), 64'(erdy));
        chk("win_valid", 64'(bus.win_valid), 64'(evld));
        chk("win_data", 64'(bus.win_data), 64'(ewin));
        chk("occ", 64'(bus.occ), 64'(mq.size()));
        chk("cons_err", 64'(bus.cons_err), 64'(merr));
    endtask

    // Next-state of the queue from the inputs currently driven.
    task automatic advance_model();
        bit accept;
        int L;
        if (!reset_l || bus.flush) begin
            mq.delete();
            merr = 1'b0;
            return;
        end
        accept = bus.fill_valid && ((DEPTH - mq.size()) >= 4);
        merr = 1'b0;
        if (bus.cons_len != 5'b0) begin
            if ($countones(bus.cons_len) == 1) begin
                L = 1;
                for (int i = 0; i < 5; i++) if (bus.cons_len[i]) L = i + 1;
                if (L <= mq.size()) begin
                    for (int i = 0; i < L; i++) void'(mq.pop_front());
                end else merr = 1'b1;
            end else merr = 1'b1;
        end
        if (accept) begin
            if (bus.fill_cnt >= 1 && bus.fill_cnt <= 4) begin
                for (int k = 0; k < int'(bus.fill_cnt); k++)
                    mq.push_back(bus.fill_data[8*k +: 8]);
            end else merr = 1'b1;
        end
    endtask

    task automatic step(input logic fv, input logic [31:0] d, input logic [2:0] cnt,
                        input logic [4:0] cl, input logic fl);
        @(negedge clk);
        bus.fill_valid = fv;
        bus.fill_data  = d;
        bus.fill_cnt   = cnt;
        bus.cons_len   = cl;
        bus.flush      = fl;
        #1;
        compare_model();
        advance_model();
    endtask

    task automatic idle();
        step(1'b0, 32'h0, 3'd4, 5'b0, 1'b0);
    endtask

    initial begin
        logic        fv, fl;
        logic [2:0]  cnt;
        logic [4:0]  cl;
        int          r;

        bus.fill_valid = 1'b0;
        bus.fill_data  = '0;
        bus.fill_cnt   = 3'd0;
        bus.cons_len   = '0;
        bus.flush      = 1'b0;
        merr = 1'b0;
        idle();
        idle();
        chk("rst_occ", 64'(bus.occ), 64'd0);
        chk("rst_ready", 64'(bus.fill_ready), 64'd1);
        chk("rst_win_valid", 64'(bus.win_valid), 64'd0);
        chk("rst_win_data", 64'(bus.win_data), 64'd0);
        reset_l = 1'b1;

        // Plan 1
        step(1'b1, 32'h11223344, 3'd4, 5'b0, 1'b0);
        idle();
        chk("p1_win", 64'(bus.win_data[31:0]), 64'h11223344);
        chk("p1_valid", 64'(bus.win_valid), 64'h0f);
        chk("p1_occ", 64'(bus.occ), 64'd4);
        chk("p1_ready", 64'(bus.fill_ready), 64'd1);

        // Plan 2
        step(1'b0, 32'h0, 3'd0, 5'b0, 1'b1);
        step(1'b1, 32'h020500B9, 3'd4, 5'b0, 1'b0);
        step(1'b1, 32'h00006001, 3'd2, 5'b0, 1'b0);
        idle();
        chk("p2_occ6", 64'(bus.occ), 64'd6);
        step(1'b0, 32'h0, 3'd0, 5'b10000, 1'b0);
        idle();
        chk("p2_occ1", 64'(bus.occ), 64'd1);
        chk("p2_byte0", 64'(bus.win_data[7:0]), 64'h60);
        chk("p2_valid", 64'(bus.win_valid), 64'h01);

        // Plan 3 then 4: fill 16 from empty, drain 14, wrap fill
        step(1'b0, 32'h0, 3'd0, 5'b0, 1'b1);
        step(1'b1, 32'h03020100, 3'd4, 5'b0, 1'b0);
        step(1'b1, 32'h07060504, 3'd4, 5'b0, 1'b0);
        step(1'b1, 32'h0B0A0908, 3'd4, 5'b0, 1'b0);
        step(1'b1, 32'hA2A10D0C, 3'd4, 5'b0, 1'b0);
        step(1'b1, 32'hDEADBEEF, 3'd4, 5'b0, 1'b0);
        chk("p3_ready", 64'(bus.fill_ready), 64'd0);
        chk("p3_valid", 64'(bus.win_valid), 64'h1f);
        idle();
        chk("p3_occ", 64'(bus.occ), 64'd16);
        step(1'b0, 32'h0, 3'd0, 5'b10000, 1'b0);
        step(1'b0, 32'h0, 3'd0, 5'b10000, 1'b0);
        step(1'b0, 32'h0, 3'd0, 5'b01000, 1'b0);
        step(1'b1, 32'h0000A4A3, 3'd2, 5'b0, 1'b0);
        idle();
        chk("p4_win", 64'(bus.win_data[31:0]), 64'hA4A3A2A1);
        chk("p4_occ", 64'(bus.occ), 64'd4);
        step(1'b0, 32'h0, 3'd0, 5'b00100, 1'b0);
        idle();
        chk("p4_byte0", 64'(bus.win_data[7:0]), 64'hA4);

        // Plan 5
        step(1'b1, 32'h00000077, 3'd1, 5'b0, 1'b0);
        step(1'b0, 32'h0, 3'd0, 5'b00100, 1'b0);
        idle();
        chk("p5_err", 64'(bus.cons_err), 64'd1);
        chk("p5_occ", 64'(bus.occ), 64'd2);
        idle();
        chk("p5_err_clear", 64'(bus.cons_err), 64'd0);
        step(1'b0, 32'h0, 3'd0, 5'b00011, 1'b0);
        idle();
        chk("p5_err_multi", 64'(bus.cons_err), 64'd1);
        chk("p5_occ_multi", 64'(bus.occ), 64'd2);
        step(1'b1, 32'h0, 3'd6, 5'b0, 1'b0);
        idle();
        chk("p5_err_cnt", 64'(bus.cons_err), 64'd1);
        chk("p5_occ_cnt", 64'(bus.occ), 64'd2);

        // Plan 6
        step(1'b1, 32'h44332211, 3'd4, 5'b0, 1'b0);
        step(1'b1, 32'h88776655, 3'd4, 5'b0, 1'b0);
        idle();
        chk("p6_occ10", 64'(bus.occ), 64'd10);
        step(1'b1, 32'h12345678, 3'd4, 5'b00001, 1'b1);
        idle();
        chk("p6_occ", 64'(bus.occ), 64'd0);
        chk("p6_valid", 64'(bus.win_valid), 64'd0);
        chk("p6_err", 64'(bus.cons_err), 64'd0);
        chk("p6_ready", 64'(bus.fill_ready), 64'd1);
        step(1'b1, 32'hCAFEF00D, 3'd4, 5'b0, 1'b0);
        step(1'b1, 32'h0BADBEEF, 3'd4, 5'b0, 1'b0);
        #1;
        reset_l = 1'b0;
        #1;
        chk("p6_async_occ", 64'(bus.occ), 64'd0);
        chk("p6_async_valid", 64'(bus.win_valid), 64'd0);
        mq.delete();
        merr = 1'b0;
        idle();
        reset_l = 1'b1;

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            fl = ($urandom_range(0, 63) == 0);
            fv = ($urandom_range(0, 3) != 0);
            r  = $urandom_range(0, 15);
            cnt = (r == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(1, 4));
            r  = $urandom_range(0, 9);
            if (r < 3)      cl = 5'b0;
            else if (r < 8) cl = 5'b00001 << $urandom_range(0, 4);
            else            cl = 5'($urandom);
            step(fv, $urandom, cnt, cl, fl);
        end
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
